// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding and counter sizing shared by the reset sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_REL  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Wide enough for the larger of the hold and inter-stage delays; never below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_button_debouncer.sv
// button_debouncer: two-flop synchroniser plus stability counter for the player reset button
module button_debouncer #(
    parameter int DEBOUNCE_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic db_button
);

    logic                     s1_q, s2_q, db_q, db_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;

    // Counter only advances while the synchronised level disagrees with the debounced one.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (s2_q != db_q) begin
            if (&db_cnt_q) db_d = s2_q;
            else db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            db_q     <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= button;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign db_button = db_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all game domains in reset, then releases them one by one and raises ready
import reset_sequencer_pkg::*;

module reset_sequencer #(
    parameter int STAGES        = 3,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 8,
    parameter int DEBOUNCE_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              soft_req,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic              db_button
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY);
    localparam int SW = $clog2(STAGES + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic              ready_q, ready_d;
    logic              trigger;

    button_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .db_button(db_button)
    );

    assign trigger = soft_req | ~db_button;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        case (state_q)
            S_HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
                if (trigger) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    rst_d   = ~(STAGES'(1));
                    cnt_d   = '0;
                    stage_d = SW'(1);
                    state_d = (STAGES == 1) ? S_RUN : S_REL;
                    ready_d = (STAGES == 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                if (trigger) begin
                    rst_d   = '1;
                    cnt_d   = '0;
                    stage_d = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(STAGE_DELAY - 1)) begin
                    rst_d   = rst_q & ~(STAGES'(1) << stage_q);
                    cnt_d   = '0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == SW'(STAGES - 1)) begin
                        ready_d = 1'b1;
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                rst_d   = '0;
                ready_d = 1'b1;
                if (trigger) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    stage_d = '0;
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random button/soft_req traffic against a timing model
module tb_reset_sequencer;

    localparam int HOLD   = 16;
    localparam int DELAY  = 8;
    localparam int DB_LEN = 16;

    logic       clk = 1'b0;
    logic       reset, button, soft_req;
    logic [2:0] rst_out;
    logic       ready, db_button;

    int checks   = 0;
    int failures = 0;

    reset_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .soft_req (soft_req),
        .rst_out  (rst_out),
        .ready    (ready),
        .db_button(db_button)
    );

    always #5 clk = ~clk;

    // Model: q = edges since the last trigger (or reset); released stage count follows from q alone.
    int   q, run;
    logic m_db, h0, h1, trig, old_s2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q = 0; run = 0; m_db = 1'b1; h0 = 1'b1; h1 = 1'b1;
        end else begin
            trig   = soft_req || !m_db;
            old_s2 = h1;
            h1     = h0;
            h0     = button;
            if (old_s2 != m_db) begin
                run++;
                if (run == DB_LEN) begin m_db = old_s2; run = 0; end
            end else run = 0;
            q = trig ? 0 : (q < 1000 ? q + 1 : q);
        end
    end

    function automatic int released(input int qq);
        int n;
        n = (qq < HOLD) ? 0 : 1 + (qq - HOLD) / DELAY;
        return (n > 3) ? 3 : n;
    endfunction

    function automatic logic [2:0] exp_rst(input int qq);
        return 3'b111 << released(qq);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_rst_out", 32'(rst_out), 32'(exp_rst(q)));
            chk("model_ready", 32'(ready), 32'(released(q) == 3));
            chk("model_db_button", 32'(db_button), 32'(m_db));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic outs(input string name, input logic [2:0] r, input logic rd);
        chk({name, "_rst"}, 32'(rst_out), 32'(r));
        chk({name, "_ready"}, 32'(ready), 32'(rd));
    endtask

    int   len;
    logic lvl;

    initial begin
        reset = 1'b1; button = 1'b1; soft_req = 1'b0;
        tick(3);
        reset = 1'b0;
        outs("reset_state", 3'b111, 1'b0);
        chk("reset_db", 32'(db_button), 32'd1);
        tick(15); outs("pwr_e15", 3'b111, 1'b0);
        tick(1);  outs("pwr_e16", 3'b110, 1'b0);
        tick(7);  outs("pwr_e23", 3'b110, 1'b0);
        tick(1);  outs("pwr_e24", 3'b100, 1'b0);
        tick(7);  outs("pwr_e31", 3'b100, 1'b0);
        tick(1);  outs("pwr_e32", 3'b000, 1'b1);

        button = 1'b0; tick(10); button = 1'b1;
        chk("glitch_db", 32'(db_button), 32'd1);
        tick(30);
        outs("glitch", 3'b000, 1'b1);

        button = 1'b0;
        tick(17); chk("press_db_e17", 32'(db_button), 32'd1);
        tick(1);  chk("press_db_e18", 32'(db_button), 32'd0);
        outs("press_e18", 3'b000, 1'b1);
        tick(1);  outs("press_e19", 3'b111, 1'b0);
        tick(21); button = 1'b1;
        outs("press_held", 3'b111, 1'b0);
        tick(17); chk("release_db_e17", 32'(db_button), 32'd0);
        tick(1);  chk("release_db_e18", 32'(db_button), 32'd1);
        tick(15); outs("rel_e15", 3'b111, 1'b0);
        tick(1);  outs("rel_e16", 3'b110, 1'b0);
        tick(16); outs("rel_e32", 3'b000, 1'b1);

        soft_req = 1'b1; tick(1); soft_req = 1'b0;
        outs("soft_e0", 3'b111, 1'b0);
        tick(15); outs("soft_e15", 3'b111, 1'b0);
        tick(1);  outs("soft_e16", 3'b110, 1'b0);
        tick(8);  outs("soft_e24", 3'b100, 1'b0);
        tick(8);  outs("soft_e32", 3'b000, 1'b1);

        soft_req = 1'b1; tick(1); soft_req = 1'b0;
        tick(16); outs("mid_pre", 3'b110, 1'b0);
        soft_req = 1'b1; tick(1); soft_req = 1'b0;
        outs("mid_restart", 3'b111, 1'b0);
        tick(15); outs("mid_e15", 3'b111, 1'b0);
        tick(1);  outs("mid_e16", 3'b110, 1'b0);

        tick(3);
        #2 reset = 1'b1;
        #1 outs("async_rst", 3'b111, 1'b0);
        tick(2); reset = 1'b0;
        tick(15); outs("async_e15", 3'b111, 1'b0);
        tick(1);  outs("async_e16", 3'b110, 1'b0);
        tick(16); outs("async_e32", 3'b000, 1'b1);

        soft_req = 1'b1; button = 1'b0; tick(1); soft_req = 1'b0;
        outs("both_e0", 3'b111, 1'b0);
        button = 1'b1; tick(60);

        len = 0; lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (len == 0) begin
                lvl = ($urandom_range(0, 3) != 0);
                len = $urandom_range(1, 80);
            end
            button   = lvl;
            len--;
            soft_req = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        soft_req = 1'b0; button = 1'b1;
        tick(80);
        outs("final", 3'b000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
